// File: rtl/ready_pack_pkg.sv
// rtl/ready_pack_pkg.sv - shared stream helpers for the pack/unpack width converters
package ready_pack_pkg;

    // Width of a lane-count field able to hold 0..ratio.
    function automatic int cnt_width(input int ratio);
        return $clog2(ratio) + 1;
    endfunction

    // Lowest bit index of a lane inside a wide word.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/ready_pack.sv
// rtl/ready_pack.sv - ready/valid upsizer packing RATIO narrow words into one wide word
module ready_pack
    import ready_pack_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int RATIO = 4
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic                         valid_i,
    input  logic [WIDTH-1:0]             dat_i,
    input  logic                         last_i,
    output logic                         ready_i,
    output logic                         valid_o,
    output logic [WIDTH*RATIO-1:0]       dat_o,
    output logic [cnt_width(RATIO)-1:0]  cnt_o,
    output logic                         last_o,
    input  logic                         ready_o
);

    localparam int CW = cnt_width(RATIO);
    localparam int KW = $clog2(RATIO);

    // Accumulator: lanes not yet written in the current packet are always zero,
    // so a flushed partial word is zero-filled without extra masking.
    logic [WIDTH*RATIO-1:0] acc_word;
    logic [KW-1:0]          k;
    logic                   acc_full;
    logic [CW-1:0]          acc_cnt;
    logic                   acc_last;

    logic                   xfer;
    logic                   at_end;
    logic                   complete;
    logic                   drain;
    logic                   out_free;
    logic                   load_new;
    logic                   hold_new;
    logic                   move_acc;
    logic                   acc_clr;
    logic                   acc_full_next;
    logic [CW-1:0]          k_cnt;
    logic [RATIO-1:0]       lane_we;
    logic [WIDTH*RATIO-1:0] new_word;

    assign xfer     = valid_i & ready_i;
    assign at_end   = (k == KW'(RATIO - 1)) | last_i;
    assign complete = xfer & at_end;
    assign drain    = valid_o & ready_o;
    assign out_free = ~valid_o | ready_o;

    // A completing word bypasses the accumulator when the output frees this cycle.
    assign load_new = complete & out_free;
    assign hold_new = complete & ~out_free;
    assign move_acc = acc_full & drain;
    assign acc_clr  = load_new | move_acc;

    assign acc_full_next = hold_new | (acc_full & ~move_acc);
    assign k_cnt         = CW'(k) + CW'(1);

    // Per-lane write enables and the word presented on a direct load.
    for (genvar j = 0; j < RATIO; j++) begin : g_lane
        assign lane_we[j] = xfer & ~load_new & (k == KW'(j));
        assign new_word[lane_lo(j, WIDTH) +: WIDTH] =
            (k == KW'(j)) ? dat_i : acc_word[lane_lo(j, WIDTH) +: WIDTH];
    end

    // Accumulator lanes: cleared whenever their content leaves for the output.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            acc_word <= '0;
        end else if (acc_clr) begin
            acc_word <= '0;
        end else begin
            for (int j = 0; j < RATIO; j++) begin
                if (lane_we[j]) begin
                    acc_word[j*WIDTH +: WIDTH] <= dat_i;
                end
            end
        end
    end

    // Fill pointer, pending-word flag and the registered input ready.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            k        <= '0;
            acc_full <= 1'b0;
            acc_cnt  <= '0;
            acc_last <= 1'b0;
            ready_i  <= 1'b1;
        end else begin
            acc_full <= acc_full_next;
            ready_i  <= ~acc_full_next;
            if (complete | move_acc) begin
                k <= '0;
            end else if (xfer) begin
                k <= k + KW'(1);
            end
            if (hold_new) begin
                acc_cnt  <= k_cnt;
                acc_last <= last_i;
            end
        end
    end

    // Output register: load a fresh word, release the held word, or go idle.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            valid_o <= 1'b0;
            dat_o   <= '0;
            cnt_o   <= '0;
            last_o  <= 1'b0;
        end else if (load_new) begin
            valid_o <= 1'b1;
            dat_o   <= new_word;
            cnt_o   <= k_cnt;
            last_o  <= last_i;
        end else if (move_acc) begin
            valid_o <= 1'b1;
            dat_o   <= acc_word;
            cnt_o   <= acc_cnt;
            last_o  <= acc_last;
        end else if (drain) begin
            valid_o <= 1'b0;
        end
    end

    // A stalled wide word stays put until the sink takes it.
    a_stable: assert property (@(posedge clk) disable iff (!arst)
        (valid_o && !ready_o) |=> (valid_o && $stable(dat_o) && $stable(cnt_o) && $stable(last_o)));

    // The lane count is always meaningful while a word is offered.
    a_cnt_range: assert property (@(posedge clk) disable iff (!arst)
        valid_o |-> (cnt_o >= CW'(1) && cnt_o <= CW'(RATIO)));

    // No word is accepted while a completed word already waits.
    a_no_loss: assert property (@(posedge clk) disable iff (!arst)
        (valid_i && ready_i) |-> !acc_full);

    // Input side is open right after reset.
    a_ready_rst: assert property (@(posedge clk) $rose(arst) |-> ready_i);

endmodule

// File: doc/ready_pack.md
# ready_pack

Ready/valid width upsizer placed directly downstream of a `ready_skid` stage. It gathers RATIO consecutive narrow words into one wide word, and lane 0 is the first word received. A `last_i` marker flushes a partially filled word early, and `cnt_o` reports how many lanes of the output word are valid. Both sides use the same ready/valid protocol as the skid stage. `ready_i` is driven from a register so the block can sit on timing-critical paths.

## Interface
- WIDTH, 16, width of one input word.
- RATIO, 4, input words per output word; legal range 2..16.
- CW, $clog2(RATIO)+1 (derived, not overridable), width of `cnt_o`.
- clk  input  1  rising-edge clock.
- arst  input  1  asynchronous, active-low reset; asserting low resets immediately, release is synchronous to clk.
- valid_i  input  1  source word valid.
- dat_i  input  WIDTH  source word.
- last_i  input  1  the current word ends a packet and forces a flush; qualified by valid_i.
- ready_i  output  1  block can accept a word; registered.
- valid_o  output  1  wide word valid.
- dat_o  output  WIDTH*RATIO  wide word; lane k occupies [k*WIDTH +: WIDTH].
- cnt_o  output  CW  number of valid lanes, 1..RATIO, while valid_o is high.
- last_o  output  1  this wide word ends a packet.
- ready_o  input  1  sink accepts the wide word.

## Operation
- Storage:
  - Accumulator: lanes acc[0..RATIO-1], fill count `k` (0..RATIO-1), flag `acc_full`.
  - Output register: dat_o, cnt_o, last_o, valid_o.
- Input transfer occurs when valid_i & ready_i; the word is written to lane k.
- The transfer completes a word when k==RATIO-1 or last_i==1. On completion:
  - Output free (!valid_o, or valid_o & ready_o in the same cycle): load the output register with acc lanes 0..k plus the new word. Lanes above k are loaded as 0. Load cnt_o = k+1, last_o = last_i, valid_o = 1. Set k = 0.
  - Output busy: hold the completed word in the accumulator, latch its cnt/last, and set acc_full. ready_i goes low the next cycle.
- A transfer that does not complete a word sets k = k+1. The output register is unaffected.
- While acc_full and the output drains (valid_o & ready_o): move the accumulator word to the output register, clear acc_full and k, and raise ready_i the next cycle.
- Output drain with nothing pending clears valid_o. dat_o/cnt_o/last_o then hold their values; they are don't-care while valid_o is low.
- Output stability: while valid_o & !ready_o, dat_o, cnt_o and last_o are stable and valid_o stays high.
- Zero-fill rule: a lane that does not receive a word in the current packet is 0 in the emitted word. Stale data from earlier packets never appears.
- ready_i is the registered value of !acc_full_next. There is no combinational path from ready_o or valid_i to ready_i.
- Reset (arst low): ready_i=1, valid_o=0, dat_o=0, cnt_o=0, last_o=0, k=0, acc_full=0, accumulator lanes 0. Reset mid-packet discards partial data; no word is emitted for it.

## Timing
- Latency: valid_o rises 1 cycle after the completing input transfer, provided the output is free.
- Throughput:
  - With ready_o held high: one input word per cycle is sustained indefinitely, including when last_i is high on every word.
  - With ready_o low: at most one completed word waits in the accumulator. ready_i drops the cycle after that word completes.
- Stall recovery: ready_i rises 1 cycle after the accumulator-to-output move.
- Simultaneous completion and output drain in one cycle: the new word goes straight to the output with no bubble, and ready_i stays high.
- Boundary case, k==RATIO-1 and last_i=1: the word counts as full; cnt_o=RATIO and last_o=1.
- Boundary case, last_i=1 with k==0: single-lane word; cnt_o=1 and lanes 1..RATIO-1 are 0.
- Protocol assumption on the source: once valid_i is high with ready_i low, dat_i and last_i are held until the transfer.

## Structure
- The shared stream package/header holds the CW width function (clog2 of RATIO plus one) and lane index/slice macros. These are reused by the matching `ready_unpack` block.
- No sub-module is required. Lane write-enable decode is a small inline generate loop. Duplicated control registers are allowed for fanout, as in the skid stage.
- Formal properties mirror the skid stage:
  - output stability under stall;
  - ready_i high after reset;
  - no lost input;
  - cnt_o within 1..RATIO while valid_o is high.

## Test plan
All scenarios use WIDTH=8 and RATIO=4.
- Full word: 01,02,03,04 on back-to-back cycles with ready_o=1 -> dat_o=32'h04030201, cnt_o=4, last_o=0; valid_o high for 1 cycle, starting the cycle after 04.
- Partial flush: AA, then BB with last_i=1 -> dat_o=32'h0000BBAA, cnt_o=2, last_o=1. The next word starts at lane 0.
- Stall: ready_o=0 while two full words arrive.
  - First word holds stable on dat_o.
  - ready_i drops after the 8th input.
  - Raising ready_o delivers word 1, then word 2.
  - ready_i rises 1 cycle after word 2 is moved to the output; no input is lost.
- Every word has last_i=1 and ready_o=1 for 10 cycles -> 10 output words, each with cnt_o=1 and last_o=1, at one per cycle.
- Reset mid-packet: after 11,22, drive arst low for 1 cycle.
  - Outputs take their reset values immediately.
  - The next words 33,44,55,66 produce exactly 32'h66554433 with cnt_o=4.
- Random throttling of valid_i and ready_o for 10k cycles, checked against a scoreboard: the output sequence equals packed input, and no stability violation occurs.
